cb_dispatch_allocator: RTL and testbench
========================================

CB_DISPATCH_ALLOCATOR -- requirements
Module: cb_dispatch_allocator

Interface
REQ-001 The block SHALL have parameter NUM_ENTRY, default 16, meaning completion-buffer entry count; it SHALL be a power of two and at least 4, and IW = log2(NUM_ENTRY).
REQ-002 The block SHALL have the following ports, one per line (name, direction, width, meaning); the design uses one clock, and reset is synchronous and active-high:
- CLK  in  1  clock, rising edge.
- RST  in  1  reset, synchronous, active-high.
- dec_valid  in  1  decode offers an instruction.
- dec_ready  out  1  allocator accepts the offered instruction.
- dec_rs1, dec_rs2, dec_rd  in  5 each  architectural register indices.
- dec_wen  in  1  instruction writes rd.
- alloc_ena  out  1  allocate the CB tail entry this cycle.
- cb_full  in  1  completion buffer full.
- cb_cur_tail  in  IW  CB tail index.
- commit_valid  in  1  CB head retires this cycle.
- commit_index  in  IW  index of the retiring entry.
- commit_rd  in  5  rd of the retiring entry.
- commit_wen  in  1  retiring entry writes rd.
- flush  in  1  CB flush.
- iss_valid  out  1  issue register holds an instruction.
- iss_ready  in  1  issue stage consumes the instruction.
- iss_index  out  IW  CB tag of the issued instruction.
- iss_rs1_busy, iss_rs2_busy  out  1 each  source has an uncommitted producer.
- iss_rs1_tag, iss_rs2_tag  out  IW each  CB index of that producer.
- iss_rd, iss_wen  out  5 / 1  registered copies of dec_rd and dec_wen.
- stall_cycles  out  32  CB-full stall count.

Function
REQ-003 accept = dec_valid & dec_ready; dec_ready SHALL equal (~iss_valid | iss_ready) & ~cb_full & ~flush.
REQ-004 alloc_ena SHALL equal accept, combinationally, in the same cycle as the handshake.
REQ-005 On accept, the issue register SHALL load at the next edge: iss_index = cb_cur_tail, iss_rd = dec_rd, iss_wen = dec_wen, plus the source lookup results; iss_valid SHALL then be 1 (latency 1 cycle).
REQ-006 If iss_valid & iss_ready and there is no accept, iss_valid SHALL clear; if there is an accept in the same cycle, the register SHALL reload instead (back-to-back throughput of 1 per cycle).
REQ-007 The block SHALL contain a register status table of 32 entries, each holding a busy bit and an IW-bit tag; entry 0 SHALL never be set busy.
REQ-008 Source lookup for rsN SHALL be as follows:
- busy = table[rsN].busy & ~commit_clear(rsN).
- tag = table[rsN].tag.
- rsN == 0 gives busy 0 and tag 0.
REQ-009 commit_clear(r) SHALL be commit_valid & commit_wen & (commit_rd == r) & (table[r].tag == commit_index); the same-cycle commit bypasses into the lookup.
REQ-010 Lookup SHALL read the table state before this instruction's own rd update (rs == rd sees the older producer).
REQ-011 On accept with dec_wen and dec_rd != 0, the table SHALL set table[dec_rd] = {busy 1, tag cb_cur_tail} at the next edge.
REQ-012 On commit_clear(r) the table SHALL clear table[r].busy at the next edge; a same-cycle allocation to the same r SHALL win (busy stays 1 with the new tag).
REQ-013 A commit whose commit_index does not match table[commit_rd].tag SHALL leave the table unchanged (the register was already reallocated by a younger producer).
REQ-014 flush SHALL force dec_ready = 0 and alloc_ena = 0 in that cycle, and at the next edge SHALL clear all busy bits and iss_valid, overriding every other update.
REQ-015 Tags SHALL wrap modulo NUM_ENTRY, taken directly from cb_cur_tail; no tag arithmetic is performed inside the block.

Reset
REQ-016 When RST = 1 at a rising edge, the block SHALL clear iss_valid, iss_index, iss_rd, iss_wen, and all table busy bits and tags, and SHALL zero stall_cycles.
REQ-017 While RST = 1, dec_ready and alloc_ena SHALL be 0, and reset SHALL have priority over flush and accept.
REQ-018 Iss_* outputs SHALL read 0 after reset; reset asserted mid-handshake SHALL discard the instruction with no allocation.

Configuration
REQ-019 With macro CB_DISPATCH_PERF_EN defined, stall_cycles SHALL increment by 1 each cycle in which dec_valid & cb_full & ~flush holds, saturating at 0xFFFFFFFF; it SHALL be cleared by reset only.
REQ-020 Without CB_DISPATCH_PERF_EN, stall_cycles SHALL be constant 0 and no counter logic SHALL be present.

Verification
REQ-021 The bench SHALL cover these directed scenarios (stimulus -> required response):
- Reset, then dec_valid=1, dec_rd=5, dec_wen=1, cb_cur_tail=3 -> alloc_ena=1 that cycle; next cycle iss_valid=1, iss_index=3, and table[5] = busy, tag 3.
- Second instruction with rs1=5, rs2=0, tail=4 -> iss_rs1_busy=1, iss_rs1_tag=3, iss_rs2_busy=0.
- Same cycle: commit_valid=1, commit_index=3, commit_rd=5, and decode reads rs1=5 -> iss_rs1_busy=0; table[5] cleared.
- rd=7 allocated at tags 2 then 6; commit index 2, rd 7 -> table[7] stays busy with tag 6.
- cb_full=1 for 10 cycles with dec_valid=1 -> dec_ready=0, alloc_ena=0; with CB_DISPATCH_PERF_EN, stall_cycles=10.
- flush while iss_valid=1 and table entries busy -> next cycle iss_valid=0 and all lookups report busy 0.

Source files
------------

// File: rtl/cb_dispatch_allocator.sv
// Dispatch allocator: decode handshake, CB tail allocation, register status table, issue register.
// Optional perf counter for CB-full stalls is built when CB_DISPATCH_PERF_EN is defined.

module cb_rst_entry #(
  parameter int IW = 4
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          flush,
  input  logic          set,
  input  logic          clr,
  input  logic [IW-1:0] set_tag,
  output logic          busy,
  output logic [IW-1:0] tag
);
  // A same-cycle allocation wins over a retiring commit of the older producer.
  always_ff @(posedge CLK) begin
    if (RST) begin
      busy <= 1'b0;
      tag  <= '0;
    end else if (flush) begin
      busy <= 1'b0;
    end else if (set) begin
      busy <= 1'b1;
      tag  <= set_tag;
    end else if (clr) begin
      busy <= 1'b0;
    end
  end
endmodule

module cb_dispatch_allocator #(
  parameter  int NUM_ENTRY = 16,
  localparam int IW        = $clog2(NUM_ENTRY)
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          dec_valid,
  output logic          dec_ready,
  input  logic [4:0]    dec_rs1,
  input  logic [4:0]    dec_rs2,
  input  logic [4:0]    dec_rd,
  input  logic          dec_wen,
  output logic          alloc_ena,
  input  logic          cb_full,
  input  logic [IW-1:0] cb_cur_tail,
  input  logic          commit_valid,
  input  logic [IW-1:0] commit_index,
  input  logic [4:0]    commit_rd,
  input  logic          commit_wen,
  input  logic          flush,
  output logic          iss_valid,
  input  logic          iss_ready,
  output logic [IW-1:0] iss_index,
  output logic          iss_rs1_busy,
  output logic          iss_rs2_busy,
  output logic [IW-1:0] iss_rs1_tag,
  output logic [IW-1:0] iss_rs2_tag,
  output logic [4:0]    iss_rd,
  output logic          iss_wen,
  output logic [31:0]   stall_cycles
);

  typedef struct packed {
    logic [IW-1:0] index;
    logic          rs1_busy;
    logic [IW-1:0] rs1_tag;
    logic          rs2_busy;
    logic [IW-1:0] rs2_tag;
    logic [4:0]    rd;
    logic          wen;
  } iss_t;

  logic                 accept;
  logic [31:0]          busy_q;
  logic [31:0][IW-1:0]  tag_q;
  logic                 commit_hit;
  logic                 iss_vld_q;
  iss_t                 iss_q, iss_d;

  assign dec_ready = ~RST & (~iss_vld_q | iss_ready) & ~cb_full & ~flush;
  assign accept    = dec_valid & dec_ready;
  assign alloc_ena = accept;

  // Commit only retires the entry if the table still points at that CB slot.
  assign commit_hit = commit_valid & commit_wen & (tag_q[commit_rd] == commit_index);

  always_comb begin
    iss_d          = '0;
    iss_d.index    = cb_cur_tail;
    iss_d.rs1_busy = busy_q[dec_rs1] & ~(commit_hit & (commit_rd == dec_rs1));
    iss_d.rs1_tag  = (dec_rs1 != 5'd0) ? tag_q[dec_rs1] : '0;
    iss_d.rs2_busy = busy_q[dec_rs2] & ~(commit_hit & (commit_rd == dec_rs2));
    iss_d.rs2_tag  = (dec_rs2 != 5'd0) ? tag_q[dec_rs2] : '0;
    iss_d.rd       = dec_rd;
    iss_d.wen      = dec_wen;
  end

  genvar i;
  generate
    for (i = 0; i < 32; i++) begin : g_rst
      if (i == 0) begin : g_zero
        assign busy_q[i] = 1'b0;
        assign tag_q[i]  = '0;
      end else begin : g_ent
        logic set_i, clr_i;
        assign set_i = accept & dec_wen & (dec_rd == 5'(i));
        assign clr_i = commit_hit & (commit_rd == 5'(i));
        cb_rst_entry #(.IW(IW)) u_ent (
          .CLK     (CLK),
          .RST     (RST),
          .flush   (flush),
          .set     (set_i),
          .clr     (clr_i),
          .set_tag (cb_cur_tail),
          .busy    (busy_q[i]),
          .tag     (tag_q[i])
        );
      end
    end
  endgenerate

  always_ff @(posedge CLK) begin
    if (RST) begin
      iss_vld_q <= 1'b0;
      iss_q     <= '0;
    end else if (flush) begin
      iss_vld_q <= 1'b0;
    end else if (accept) begin
      iss_vld_q <= 1'b1;
      iss_q     <= iss_d;
    end else if (iss_ready) begin
      iss_vld_q <= 1'b0;
    end
  end

  assign iss_valid    = iss_vld_q;
  assign iss_index    = iss_q.index;
  assign iss_rs1_busy = iss_q.rs1_busy;
  assign iss_rs1_tag  = iss_q.rs1_tag;
  assign iss_rs2_busy = iss_q.rs2_busy;
  assign iss_rs2_tag  = iss_q.rs2_tag;
  assign iss_rd       = iss_q.rd;
  assign iss_wen      = iss_q.wen;

`ifdef CB_DISPATCH_PERF_EN
  logic [31:0] stall_q;
  always_ff @(posedge CLK) begin
    if (RST)
      stall_q <= '0;
    else if (dec_valid & cb_full & ~flush & (stall_q != '1))
      stall_q <= stall_q + 32'd1;
  end
  assign stall_cycles = stall_q;
`else
  assign stall_cycles = '0;
`endif

endmodule

// File: tb/tb_cb_dispatch_allocator.sv
// Directed bench for cb_dispatch_allocator; expected issue records go through a scoreboard queue.
module tb_cb_dispatch_allocator;
  localparam int IW = 4;

  logic          CLK = 1'b0;
  logic          RST;
  logic          dec_valid, dec_ready, dec_wen, alloc_ena, cb_full;
  logic [4:0]    dec_rs1, dec_rs2, dec_rd, commit_rd, iss_rd;
  logic [IW-1:0] cb_cur_tail, commit_index, iss_index, iss_rs1_tag, iss_rs2_tag;
  logic          commit_valid, commit_wen, flush, iss_valid, iss_ready, iss_wen;
  logic          iss_rs1_busy, iss_rs2_busy;
  logic [31:0]   stall_cycles;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic [IW-1:0] idx;
    logic          b1;
    logic [IW-1:0] t1;
    logic          b2;
    logic [IW-1:0] t2;
    logic [4:0]    rd;
    logic          wen;
  } exp_t;
  exp_t sb[$];

  always #5 CLK = ~CLK;

  cb_dispatch_allocator dut (
    .CLK(CLK), .RST(RST), .dec_valid(dec_valid), .dec_ready(dec_ready),
    .dec_rs1(dec_rs1), .dec_rs2(dec_rs2), .dec_rd(dec_rd), .dec_wen(dec_wen),
    .alloc_ena(alloc_ena), .cb_full(cb_full), .cb_cur_tail(cb_cur_tail),
    .commit_valid(commit_valid), .commit_index(commit_index), .commit_rd(commit_rd),
    .commit_wen(commit_wen), .flush(flush), .iss_valid(iss_valid), .iss_ready(iss_ready),
    .iss_index(iss_index), .iss_rs1_busy(iss_rs1_busy), .iss_rs2_busy(iss_rs2_busy),
    .iss_rs1_tag(iss_rs1_tag), .iss_rs2_tag(iss_rs2_tag), .iss_rd(iss_rd),
    .iss_wen(iss_wen), .stall_cycles(stall_cycles)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Offer one instruction, expect it accepted, then compare the issued record next cycle.
  task automatic issue(input string tag, input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic [4:0] rd, input logic wen, input logic [IW-1:0] tail,
                       input logic b1, input logic [IW-1:0] t1,
                       input logic b2, input logic [IW-1:0] t2);
    exp_t e;
    dec_valid = 1'b1; dec_rs1 = rs1; dec_rs2 = rs2; dec_rd = rd; dec_wen = wen;
    cb_cur_tail = tail;
    #1;
    chk({tag, ".alloc"}, 32'(alloc_ena), 32'd1);
    e.idx = tail; e.b1 = b1; e.t1 = t1; e.b2 = b2; e.t2 = t2; e.rd = rd; e.wen = wen;
    if (alloc_ena) sb.push_back(e);
    tick();
    dec_valid = 1'b0;
    if (sb.size() == 0) begin
      chk({tag, ".sb_empty"}, 32'd0, 32'd1);
    end else begin
      e = sb.pop_front();
      chk({tag, ".vld"},   32'(iss_valid),    32'd1);
      chk({tag, ".idx"},   32'(iss_index),    32'(e.idx));
      chk({tag, ".b1"},    32'(iss_rs1_busy), 32'(e.b1));
      chk({tag, ".t1"},    32'(iss_rs1_tag),  32'(e.t1));
      chk({tag, ".b2"},    32'(iss_rs2_busy), 32'(e.b2));
      chk({tag, ".t2"},    32'(iss_rs2_tag),  32'(e.t2));
      chk({tag, ".rd"},    32'(iss_rd),       32'(e.rd));
      chk({tag, ".wen"},   32'(iss_wen),      32'(e.wen));
    end
  endtask

  initial begin
    RST = 1'b1; dec_valid = 1'b1; dec_rs1 = '0; dec_rs2 = '0; dec_rd = 5'd3; dec_wen = 1'b1;
    cb_full = 1'b0; cb_cur_tail = '0; commit_valid = 1'b0; commit_index = '0;
    commit_rd = '0; commit_wen = 1'b0; flush = 1'b0; iss_ready = 1'b1;
    tick(); tick();
    chk("rst.ready", 32'(dec_ready), 32'd0);
    chk("rst.alloc", 32'(alloc_ena), 32'd0);
    chk("rst.vld",   32'(iss_valid), 32'd0);
    chk("rst.idx",   32'(iss_index), 32'd0);
    chk("rst.rd",    32'(iss_rd),    32'd0);
    chk("rst.stall", stall_cycles,   32'd0);
    RST = 1'b0; dec_valid = 1'b0;

    issue("i1", 5'd0, 5'd0, 5'd5, 1'b1, 4'd3, 1'b0, 4'd0, 1'b0, 4'd0);
    issue("i2", 5'd5, 5'd0, 5'd0, 1'b0, 4'd4, 1'b1, 4'd3, 1'b0, 4'd0);
    // Commit of the producer bypasses into the same-cycle lookup.
    commit_valid = 1'b1; commit_index = 4'd3; commit_rd = 5'd5; commit_wen = 1'b1;
    issue("byp", 5'd5, 5'd0, 5'd0, 1'b0, 4'd5, 1'b0, 4'd3, 1'b0, 4'd0);
    commit_valid = 1'b0;
    issue("clr5", 5'd5, 5'd5, 5'd0, 1'b0, 4'd6, 1'b0, 4'd3, 1'b0, 4'd3);

    // Stale commit must not clear a reallocated register.
    issue("r7a", 5'd0, 5'd0, 5'd7, 1'b1, 4'd2, 1'b0, 4'd0, 1'b0, 4'd0);
    issue("r7b", 5'd0, 5'd0, 5'd7, 1'b1, 4'd6, 1'b0, 4'd0, 1'b0, 4'd0);
    commit_valid = 1'b1; commit_index = 4'd2; commit_rd = 5'd7; commit_wen = 1'b1;
    tick();
    commit_valid = 1'b0;
    chk("idle.vld", 32'(iss_valid), 32'd0);
    issue("stale", 5'd7, 5'd7, 5'd0, 1'b0, 4'd7, 1'b1, 4'd6, 1'b1, 4'd6);
    issue("rsrd",  5'd7, 5'd0, 5'd7, 1'b1, 4'd8, 1'b1, 4'd6, 1'b0, 4'd0);
    issue("newer", 5'd7, 5'd0, 5'd9, 1'b1, 4'd9, 1'b1, 4'd8, 1'b0, 4'd0);

    // Issue stage back-pressure blocks decode.
    iss_ready = 1'b0; dec_valid = 1'b1; #1;
    chk("bp.ready", 32'(dec_ready), 32'd0);
    chk("bp.alloc", 32'(alloc_ena), 32'd0);
    tick();
    chk("bp.hold", 32'(iss_valid), 32'd1);
    chk("bp.idx",  32'(iss_index), 32'd9);
    iss_ready = 1'b1;

    cb_full = 1'b1; dec_valid = 1'b1;
    for (int k = 0; k < 10; k++) begin
      #1;
      chk("full.ready", 32'(dec_ready), 32'd0);
      chk("full.alloc", 32'(alloc_ena), 32'd0);
      tick();
    end
    cb_full = 1'b0; dec_valid = 1'b0;
`ifdef CB_DISPATCH_PERF_EN
    chk("stall", stall_cycles, 32'd10);
`else
    chk("stall", stall_cycles, 32'd0);
`endif

    // Flush with a valid issue register and busy entries 7 and 9.
    issue("pre_fl", 5'd9, 5'd0, 5'd0, 1'b0, 4'd10, 1'b1, 4'd9, 1'b0, 4'd0);
    flush = 1'b1; dec_valid = 1'b1; #1;
    chk("fl.ready", 32'(dec_ready), 32'd0);
    chk("fl.alloc", 32'(alloc_ena), 32'd0);
    tick();
    flush = 1'b0; dec_valid = 1'b0;
    chk("fl.vld", 32'(iss_valid), 32'd0);
    chk("fl.stall_kept", 32'(stall_cycles != 32'd0),
`ifdef CB_DISPATCH_PERF_EN
        32'd1);
`else
        32'd0);
`endif
    issue("post_fl", 5'd7, 5'd9, 5'd5, 1'b1, 4'd11, 1'b0, 4'd8, 1'b0, 4'd9);

    // Reset mid-handshake discards the instruction and clears the table.
    dec_valid = 1'b1; dec_rd = 5'd4; dec_wen = 1'b1; cb_cur_tail = 4'd12; RST = 1'b1; #1;
    chk("rmid.alloc", 32'(alloc_ena), 32'd0);
    tick();
    RST = 1'b0; dec_valid = 1'b0;
    chk("rmid.vld", 32'(iss_valid), 32'd0);
    chk("rmid.idx", 32'(iss_index), 32'd0);
    chk("rmid.stall", stall_cycles, 32'd0);
    issue("post_rst", 5'd5, 5'd4, 5'd0, 1'b0, 4'd13, 1'b0, 4'd0, 1'b0, 4'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
